// File: rtl/alu_deserializer.sv
// Serial command receiver: eight DATA packets carry operands B then A, one CTL
// packet carries opcode and CRC4; emits a checked ALU command or an error pulse.
module alu_deserializer #(
  parameter bit CRC_CHECK_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [2:0]  op_o,
  output logic        valid_o,
  output logic        err_o,
  output logic [2:0]  err_flags_o
);

  // state     | meaning
  // S_IDLE    | line idle, waiting for start bit (sin=0)
  // S_TYPE    | sampling packet type bit (0 DATA, 1 CTL)
  // S_PAYLOAD | sampling 8 payload bits, MSB first
  // S_STOP    | sampling stop bit, command decision on CTL
  // S_RECOVER | bad stop bit seen, waiting for sin=1
  typedef enum logic [2:0] {S_IDLE, S_TYPE, S_PAYLOAD, S_STOP, S_RECOVER} state_t;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q;
  logic        pkt_type_q;
  logic [7:0]  payload_q;
  logic [3:0]  data_cnt_q;
  logic [63:0] ba_q;

  logic        stop_bad, ctl_done, data_done;
  logic        e_data, e_crc, e_op, cmd_err, cmd_ok;
  logic [3:0]  crc_calc;
  logic [2:0]  op_rx;

  // Shift-register CRC, x^4+x+1, zero init, MSB first.
  function automatic logic [3:0] crc4(input logic [67:0] msg);
    logic [3:0] c;
    c = 4'b0000;
    for (int i = 67; i >= 0; i--) begin
      if (c[3] ^ msg[i]) c = {c[2:0], 1'b0} ^ 4'b0011;
      else               c = {c[2:0], 1'b0};
    end
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (!sin) state_d = S_TYPE;
      S_TYPE:    state_d = S_PAYLOAD;
      S_PAYLOAD: if (bit_cnt_q == 3'd7) state_d = S_STOP;
      S_STOP:    state_d = sin ? S_IDLE : S_RECOVER;
      S_RECOVER: if (sin) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_rx     = payload_q[6:4];
    crc_calc  = crc4({ba_q, 1'b1, op_rx});
    stop_bad  = (state_q == S_STOP) && !sin;
    ctl_done  = (state_q == S_STOP) && sin && pkt_type_q;
    data_done = (state_q == S_STOP) && sin && !pkt_type_q;
    e_data    = stop_bad || (ctl_done && ((data_cnt_q != 4'd8) || payload_q[7]));
    e_crc     = ctl_done && !e_data && CRC_CHECK_EN && (crc_calc != payload_q[3:0]);
    e_op      = ctl_done && !e_data && !e_crc &&
                !((op_rx == 3'b000) || (op_rx == 3'b001) ||
                  (op_rx == 3'b100) || (op_rx == 3'b101));
    cmd_err   = e_data || e_crc || e_op;
    cmd_ok    = ctl_done && !cmd_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      pkt_type_q  <= 1'b0;
      payload_q   <= 8'd0;
      data_cnt_q  <= 4'd0;
      ba_q        <= 64'd0;
      a_o         <= 32'd0;
      b_o         <= 32'd0;
      op_o        <= 3'd0;
      valid_o     <= 1'b0;
      err_o       <= 1'b0;
      err_flags_o <= 3'd0;
    end else begin
      state_q     <= state_d;
      valid_o     <= cmd_ok;
      err_o       <= cmd_err;
      err_flags_o <= {e_data, e_crc, e_op};
      if (state_q == S_TYPE) begin
        pkt_type_q <= sin;
        bit_cnt_q  <= 3'd0;
      end
      if (state_q == S_PAYLOAD) begin
        payload_q <= {payload_q[6:0], sin};
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      if (data_done) begin
        ba_q <= {ba_q[55:0], payload_q};
        if (data_cnt_q != 4'd9) data_cnt_q <= data_cnt_q + 4'd1;
      end
      // Any command outcome, good or bad, starts the next command from scratch.
      if (ctl_done || stop_bad) begin
        ba_q       <= 64'd0;
        data_cnt_q <= 4'd0;
      end
      if (cmd_ok) begin
        b_o  <= ba_q[63:32];
        a_o  <= ba_q[31:0];
        op_o <= op_rx;
      end
    end
  end

endmodule

// File: tb/tb_alu_deserializer.sv
// Directed bench for alu_deserializer: two instances (CRC checked / skipped)
// share the serial line; expected CRCs and results are hand-derived constants.
module tb_alu_deserializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sin = 1'b1;
  logic [31:0] a0, b0, a1, b1;
  logic [2:0]  op0, op1, fl0, fl1;
  logic        v0, e0, v1, e1;

  int n_chk = 0;
  int n_pass = 0;
  int v0_cnt = 0;
  int e0_cnt = 0;

  alu_deserializer #(.CRC_CHECK_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin), .a_o(a0), .b_o(b0), .op_o(op0),
    .valid_o(v0), .err_o(e0), .err_flags_o(fl0)
  );

  alu_deserializer #(.CRC_CHECK_EN(1'b0)) dut_nocrc (
    .clk(clk), .rst_n(rst_n), .sin(sin), .a_o(a1), .b_o(b1), .op_o(op1),
    .valid_o(v1), .err_o(e1), .err_flags_o(fl1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (v0) v0_cnt++;
    if (e0) e0_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_bit(input logic b);
    sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic typ, input logic [7:0] pl, input logic stop);
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(pl[i]);
    send_bit(stop);
  endtask

  task automatic send_cmd(input logic [63:0] ba, input int ndata, input logic [7:0] ctl,
                          input int gap);
    for (int i = 0; i < ndata; i++) begin
      send_pkt(1'b0, ba[63 - 8 * (i % 8) -: 8], 1'b1);
      for (int g = 0; g < gap; g++) send_bit(1'b1);
    end
    send_pkt(1'b1, ctl, 1'b1);
  endtask

  task automatic expect_out(input string tag, input logic ev, input logic ee,
                            input logic [2:0] ef, input logic [31:0] ea,
                            input logic [31:0] eb, input logic [2:0] eop);
    chk({tag, "_valid"}, 64'(v0), 64'(ev));
    chk({tag, "_err"}, 64'(e0), 64'(ee));
    chk({tag, "_flags"}, 64'(fl0), 64'(ef));
    chk({tag, "_a"}, 64'(a0), 64'(ea));
    chk({tag, "_b"}, 64'(b0), 64'(eb));
    chk({tag, "_op"}, 64'(op0), 64'(eop));
  endtask

  task automatic expect_quiet(input string tag);
    send_bit(1'b1);
    chk({tag, "_pulse_end"}, {62'd0, v0, e0}, 64'd0);
    chk({tag, "_flags_end"}, 64'(fl0), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    expect_out("reset", 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 3'd0);
    rst_n = 1'b1;
    repeat (2) send_bit(1'b1);

    // All-zero operands, op=000, crc=1011
    send_cmd(64'd0, 8, 8'h0B, 2);
    expect_out("zero", 1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 3'b000);
    chk("zero_nocrc_valid", 64'(v1), 64'd1);
    expect_quiet("zero");

    // B=1, A=2, add, crc=1010, back-to-back packets
    send_cmd({32'd1, 32'd2}, 8, 8'h4A, 0);
    expect_out("add", 1'b1, 1'b0, 3'b000, 32'd2, 32'd1, 3'b100);
    expect_quiet("add");

    // Only 7 DATA packets
    send_cmd(64'hDEAD_BEEF_1234_5678, 7, 8'h0B, 1);
    expect_out("short", 1'b0, 1'b1, 3'b100, 32'd2, 32'd1, 3'b100);
    expect_quiet("short");

    // Wrong CRC: rejected when checked, accepted when not
    send_cmd(64'd0, 8, 8'h00, 0);
    expect_out("badcrc", 1'b0, 1'b1, 3'b010, 32'd2, 32'd1, 3'b100);
    chk("badcrc_nocrc_valid", 64'(v1), 64'd1);
    chk("badcrc_nocrc_b", 64'(b1), 64'd0);
    chk("badcrc_nocrc_err", 64'(e1), 64'd0);
    expect_quiet("badcrc");

    // Illegal op 111 with correct crc=0010
    send_cmd(64'd0, 8, 8'h72, 0);
    expect_out("badop", 1'b0, 1'b1, 3'b001, 32'd2, 32'd1, 3'b100);
    chk("badop_nocrc_flags", 64'(fl1), 64'b001);
    expect_quiet("badop");

    // CTL payload bit 7 set outranks everything
    send_cmd(64'd0, 8, 8'h8B, 0);
    expect_out("ctlb7", 1'b0, 1'b1, 3'b100, 32'd2, 32'd1, 3'b100);
    expect_quiet("ctlb7");

    // Nine DATA packets
    send_cmd(64'd0, 9, 8'h0B, 0);
    expect_out("long", 1'b0, 1'b1, 3'b100, 32'd2, 32'd1, 3'b100);
    expect_quiet("long");

    // Bad stop bit mid-command, line held low, then a clean command (op=001, crc=1000)
    for (int i = 0; i < 3; i++) send_pkt(1'b0, 8'hA5, 1'b1);
    send_pkt(1'b0, 8'h5A, 1'b0);
    expect_out("stoperr", 1'b0, 1'b1, 3'b100, 32'd2, 32'd1, 3'b100);
    repeat (4) send_bit(1'b0);
    chk("stoperr_hold", {62'd0, v0, e0}, 64'd0);
    send_bit(1'b1);
    send_cmd(64'd0, 8, 8'h18, 0);
    expect_out("recover", 1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 3'b001);
    expect_quiet("recover");

    // Reset during 5th DATA packet, then a fresh command
    for (int i = 0; i < 4; i++) send_pkt(1'b0, 8'hFF, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    rst_n = 1'b0;
    #3;
    chk("midrst_op", 64'(op0), 64'd0);
    chk("midrst_flags", {61'd0, v0, e0, 1'b0}, 64'd0);
    send_bit(1'b1);
    rst_n = 1'b1;
    send_bit(1'b1);
    send_cmd({32'd1, 32'd2}, 8, 8'h4A, 1);
    expect_out("postrst", 1'b1, 1'b0, 3'b000, 32'd2, 32'd1, 3'b100);
    expect_quiet("postrst");

    repeat (3) send_bit(1'b1);
    chk("valid_pulses", 64'(v0_cnt), 64'd4);
    chk("err_pulses", 64'(e0_cnt), 64'd6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_deserializer.md
ALU_DESERIALIZER -- requirements
Module: alu_deserializer

Interface
REQ-001 SHALL have parameter CRC_CHECK_EN, default 1, meaning 1 enables CRC checking and 0 skips it (CRC error never flagged).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port sin  input  1  serial command line, idle high.
REQ-005 SHALL have port a_o  output  32  operand A.
REQ-006 SHALL have port b_o  output  32  operand B.
REQ-007 SHALL have port op_o  output  3  opcode (and=000, or=001, add=100, sub=101).
REQ-008 SHALL have port valid_o  output  1  one-cycle pulse, a_o/b_o/op_o valid.
REQ-009 SHALL have port err_o  output  1  one-cycle pulse, command rejected.
REQ-010 SHALL have port err_flags_o  output  3  {err_data, err_crc, err_op}, onehot when err_o=1.

Function
REQ-011 SHALL sample sin once per clk; packet = start 0, type bit (0 DATA, 1 CTL), 8 payload bits MSB first, stop 1 (11 bits).
REQ-012 SHALL use bit-level FSM IDLE -> TYPE -> PAYLOAD (8 cycles, counter 0..7) -> STOP -> IDLE; IDLE leaves only on sin=0.
REQ-013 SHALL allow any number of idle (sin=1) cycles between packets, including zero.
REQ-014 SHALL expect command = 8 DATA packets (B[31:24], B[23:16], B[15:8], B[7:0], A[31:24]..A[7:0]) then 1 CTL packet {0, op[2:0], crc[3:0]}.
REQ-015 SHALL count DATA packets in a 4-bit counter saturating at 9; shift each payload into a 64-bit {B,A} register.
REQ-016 SHALL compute CRC4, polynomial x^4+x+1, init 4'b0000, over 68 bits {B, A, 1'b1, op} MSB first.
REQ-017 SHALL, one cycle after the CTL stop bit is sampled, pulse exactly one of valid_o or err_o.
REQ-018 SHALL flag err_data when CTL arrives with data count != 8, when CTL payload bit 7 = 1, or when any stop bit samples 0.
REQ-019 SHALL flag err_crc when err_data clear, CRC_CHECK_EN=1 and received crc != computed crc.
REQ-020 SHALL flag err_op when err_data and err_crc clear and op not in {000,001,100,101}.
REQ-021 SHALL set priority err_data > err_crc > err_op; only the highest flag asserted.
REQ-022 SHALL, on a stop-bit error, pulse err_o with err_data the next cycle, discard the command, and return to IDLE only after sampling sin=1.
REQ-023 SHALL clear data counter and CRC state after every valid_o or err_o, starting the next command cleanly.
REQ-024 SHALL update a_o/b_o/op_o only together with valid_o and hold them otherwise; err_flags_o SHALL be 0 whenever err_o=0.
REQ-025 SHALL ignore sin=0 during a stop-bit recovery wait until sin=1 has been sampled.

Reset
REQ-026 SHALL, on rst_n low, asynchronously force FSM IDLE, counters 0, {B,A} 0, a_o=0, b_o=0, op_o=0, valid_o=0, err_o=0, err_flags_o=0.
REQ-027 SHALL discard any partial packet or command when reset asserts mid-operation; first start bit after release begins a new command.

Verification
REQ-028 SHALL pass: B=0, A=0, CTL {0,000,1011} -> valid_o pulse 1 cycle after CTL stop, a_o=0, b_o=0, op_o=000, err_o=0.
REQ-029 SHALL pass: B=32'h0000_0001, A=32'h0000_0002, op=100, correct CRC -> valid_o, b_o=1, a_o=2, op_o=100.
REQ-030 SHALL pass: 7 DATA packets then CTL -> err_o with err_flags_o=3'b100, no valid_o, a_o/b_o unchanged.
REQ-031 SHALL pass: B=0, A=0, CTL {0,000,0000} -> err_o, err_flags_o=3'b010; with CRC_CHECK_EN=0 -> valid_o.
REQ-032 SHALL pass: B=0, A=0, op=111, correct CRC -> err_o, err_flags_o=3'b001.
REQ-033 SHALL pass: rst_n low during 5th DATA packet, then full valid command -> single valid_o with new operands only.
